// File: rtl/alu_slice_1b.sv
// Registered 1-bit ALU slice: half-add, full-add, compare, full-subtract selected by {M1,M0}.
// Define ALU_SLICE_STICKY_EN to add the sticky_c carry-seen flag.
module alu_slice_1b (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    input  logic       M0,
    input  logic       M1,
    output logic       F,
    output logic       Cout,
    output logic       N,
    output logic       out_valid,
    output logic [3:0] mode_oh
`ifdef ALU_SLICE_STICKY_EN
    ,
    output logic       sticky_c
`endif
);

    logic [3:0] mode_oh_d, mode_oh_q;
    logic       f_d, f_q;
    logic       c_d, c_q;
    logic       n_d, n_q;
    logic       vld_q;
    logic       axb;

    always_comb begin
        mode_oh_d = 4'b0001 << {M1, M0};
        axb       = A ^ B;
        // Each mode term is gated by its one-hot bit, so the ORs act as a 4:1 mux.
        f_d = (mode_oh_d[0] & axb)
            | (mode_oh_d[1] & (axb ^ Cin))
            | (mode_oh_d[2] & ~axb)
            | (mode_oh_d[3] & (axb ^ Cin));
        c_d = (mode_oh_d[0] & (A & B))
            | (mode_oh_d[1] & ((A & B) | (A & Cin) | (B & Cin)))
            | (mode_oh_d[2] & (A & ~B))
            | (mode_oh_d[3] & ((~A & B) | (~A & Cin) | (B & Cin)));
        n_d = (mode_oh_d[2] & (~A & B))
            | (mode_oh_d[3] & ((~A & B) | (~A & Cin) | (B & Cin)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q       <= 1'b0;
            c_q       <= 1'b0;
            n_q       <= 1'b0;
            vld_q     <= 1'b0;
            mode_oh_q <= 4'b0000;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                f_q       <= f_d;
                c_q       <= c_d;
                n_q       <= n_d;
                mode_oh_q <= mode_oh_d;
            end
        end
    end

`ifdef ALU_SLICE_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (in_valid && c_d) begin
            sticky_q <= 1'b1;
        end
    end

    assign sticky_c = sticky_q;
`endif

    assign F         = f_q;
    assign Cout      = c_q;
    assign N         = n_q;
    assign out_valid = vld_q;
    assign mode_oh   = mode_oh_q;

endmodule

// File: tb/tb_alu_slice_1b.sv
// Scoreboard bench for alu_slice_1b: directed vectors push expected results, a monitor pops and checks.
module tb_alu_slice_1b;

    logic       clk = 1'b0;
    logic       rst, in_valid, A, B, Cin, M0, M1;
    logic       F, Cout, N, out_valid;
    logic [3:0] mode_oh;
`ifdef ALU_SLICE_STICKY_EN
    logic       sticky_c;
`endif

    alu_slice_1b dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(A), .B(B), .Cin(Cin), .M0(M0), .M1(M1),
        .F(F), .Cout(Cout), .N(N), .out_valid(out_valid), .mode_oh(mode_oh)
`ifdef ALU_SLICE_STICKY_EN
        , .sticky_c(sticky_c)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       f;
        logic       c;
        logic       n;
        logic [3:0] oh;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {ov,F,C,N,oh}=%b, expected %b", nm, $time, act, exp);
        end
    endtask

    // Monitor: held values model what outputs must show when no new result arrives.
    logic       r_smp;
    exp_t       held = '0;
    exp_t       e;
    logic       hs = 1'b0;

    always begin
        @(posedge clk);
        r_smp = rst;
        #1;
        if (r_smp) begin
            held = '0;
            hs   = 1'b0;
            q.delete();
            chk("reset", {out_valid, F, Cout, N, mode_oh}, 8'b0);
        end else if (out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_valid @%0t: got out_valid=1, expected 0 (no pending result)", $time);
            end else begin
                e    = q.pop_front();
                held = e;
                hs   = hs | e.c;
                chk("result", {out_valid, F, Cout, N, mode_oh}, {1'b1, e});
            end
        end else begin
            n_chk++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL missing_valid @%0t: got out_valid=0, expected 1 (%0d pending)", $time, q.size());
                void'(q.pop_front());
            end
            chk("hold", {out_valid, F, Cout, N, mode_oh}, {1'b0, held});
        end
`ifdef ALU_SLICE_STICKY_EN
        n_chk++;
        if (sticky_c !== hs) begin
            n_fail++;
            $display("FAIL sticky @%0t: got %b, expected %b", $time, sticky_c, hs);
        end
`endif
    end

    task automatic vec(input logic [1:0] m, input logic a, input logic b, input logic ci,
                       input logic ef, input logic ec, input logic en);
        exp_t x;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1;
        {M1, M0} = m; A = a; B = b; Cin = ci;
        x.f = ef; x.c = ec; x.n = en;
        x.oh = 4'b0001 << m;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b0;
            A = ~A; B = $urandom_range(0, 1); Cin = ~Cin; {M1, M0} = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic rst_pulse;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        A = 1'b1; B = 1'b1; Cin = 1'b1; {M1, M0} = 2'b01;
    endtask

    // Full-add {Cout,F} for {A,B,Cin} = 0..7
    logic [1:0] fa_cf [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        rst = 1'b1; in_valid = 1'b1;
        A = 1'b1; B = 1'b1; Cin = 1'b1; {M1, M0} = 2'b01;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] cf;
            v  = 3'(i);
            cf = fa_cf[i];
            vec(2'b01, v[2], v[1], v[0], cf[0], cf[1], 1'b0);
        end

        vec(2'b00, 1, 1, 1, 0, 1, 0);
        vec(2'b00, 1, 0, 1, 1, 0, 0);
        vec(2'b10, 0, 0, 1, 1, 0, 0);
        vec(2'b10, 1, 0, 0, 0, 1, 0);
        vec(2'b10, 0, 1, 1, 0, 0, 1);
        vec(2'b10, 1, 1, 0, 1, 0, 0);
        vec(2'b11, 0, 1, 0, 1, 1, 1);
        vec(2'b11, 1, 0, 0, 1, 0, 0);
        vec(2'b11, 0, 0, 1, 1, 1, 1);
        vec(2'b11, 1, 1, 1, 1, 1, 1);

        idle(3);

        vec(2'b01, 1, 0, 0, 1, 0, 0);
        rst_pulse();
        idle(2);

        vec(2'b01, 1, 1, 0, 0, 1, 0);
        vec(2'b01, 0, 0, 0, 0, 0, 0);
        idle(2);
        vec(2'b00, 0, 0, 0, 0, 0, 0);
        rst_pulse();
        idle(2);

        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending results, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_slice_1b.md
Name: alu_slice_1b

Overview:
- Registered 1-bit ALU slice with a 2-bit mode select (M1,M0).
- Mode is decoded one-hot 2-to-4 to choose between half-add, full-add, 1-bit compare and full-subtract.
- Results F, Cout and N are registered on the clock edge; one output per input sample.
- Used as the bit-slice building block of the 4-bit ALU; Cout/Cin chain externally between slices.

Parameters:
- None. Data width is fixed at 1 bit.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample qualifier; operands captured only when high
- A  input  1  operand A
- B  input  1  operand B
- Cin  input  1  carry/borrow in
- M0  input  1  mode select LSB
- M1  input  1  mode select MSB
- F  output  1  result bit, registered
- Cout  output  1  carry / borrow / greater-than flag, registered
- N  output  1  less-than / borrow flag, registered
- out_valid  output  1  high for one cycle when F/Cout/N hold a new result
- mode_oh  output  4  registered one-hot decode of {M1,M0}; bit k set for mode k

Behaviour:
- Reset (rst=1 at rising edge): F=0, Cout=0, N=0, out_valid=0, mode_oh=4'b0000. rst has priority over in_valid.
- Latency: exactly 1 cycle. Inputs sampled at edge k with in_valid=1 give results valid after edge k, with out_valid=1 in that cycle.
- in_valid=0: F, Cout, N and mode_oh hold their previous values; out_valid=0.
- Back-to-back in_valid=1 every cycle gives full throughput, one result per cycle, with no stall or backpressure.
- Mode 00, half add (Cin ignored): F=A^B; Cout=A&B; N=0.
- Mode 01, full add: F=A^B^Cin; Cout=(A&B)|(A&Cin)|(B&Cin); N=0.
- Mode 10, compare (Cin ignored): F=~(A^B), equal; Cout=A&~B, A>B; N=~A&B, A<B. Exactly one of F/Cout/N is 1.
- Mode 11, full subtract A-B-Cin: F=A^B^Cin; Cout=borrow=(~A&B)|(~A&Cin)|(B&Cin); N=Cout.
- All logic is pure combinational from the sampled inputs; no dependency on previous results except in the optional feature.
- X/Z on inputs while in_valid=0 must not disturb outputs.

Optional Feature:
- Macro ALU_SLICE_STICKY_EN.
- When defined, add output port sticky_c (1 bit).
- sticky_c resets to 0 on rst.
- sticky_c sets to 1 at any edge where in_valid=1 and the newly computed Cout=1; it stays 1 until rst.
- When not defined, the port is absent and no extra flop exists.

Test Plan:
- Reset: drive rst=1 for 2 cycles with A=B=Cin=1, mode 01, in_valid=1 -> F=0, Cout=0, N=0, out_valid=0, mode_oh=0000.
- Full add sweep: mode 01, in_valid=1, A/B/Cin stepped 000..111 one per cycle -> next-cycle {Cout,F} = 00,01,01,10,01,10,10,11; N=0 throughout; mode_oh=0010.
- Half add / compare: mode 00 with A=1,B=1,Cin=1 -> F=0, Cout=1, N=0. Then mode 10 with (A,B)=(0,0),(1,0),(0,1) -> {F,Cout,N} = 100, 010, 001.
- Subtract: mode 11 with (A,B,Cin)=(0,1,0) -> F=1, Cout=1, N=1; (1,0,0) -> F=1, Cout=0, N=0; (1,1,1) -> F=1, Cout=1, N=1.
- Hold: after a result of F=1, drop in_valid for 3 cycles while toggling A/B -> F/Cout/N unchanged, out_valid=0. Assert rst mid-stream with in_valid=1 -> outputs cleared next edge.
- Sticky (macro defined): mode 01, A=B=1 produces Cout=1, then A=B=0 -> sticky_c stays 1 until rst; with macro undefined the build has no sticky_c port.
